// File: rtl/alu_div_sequencer_pkg.sv
// Shared ALU definitions: datapath width, divider sequencer states and the
// quotient reported for a zero divisor.
package alu_div_sequencer_pkg;

  localparam int ALU_WIDTH = 6;

  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_div_sequencer_sub.sv
// The ALU's shared 6-bit subtraction unit. The result is modulo 2^ALU_WIDTH,
// so callers must compare the operands first if a wrap is not wanted.
module alu_div_sequencer_sub
  import alu_div_sequencer_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] minuend,
  input  logic [ALU_WIDTH-1:0] subtrahend,
  output logic [ALU_WIDTH-1:0] difference
);

  assign difference = minuend - subtrahend;

endmodule

// File: rtl/alu_div_sequencer.sv
// Unsigned 6-bit divider that uses repeated subtraction on the shared
// subtraction unit, with valid/ready handshakes on the operand and result sides.
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_WIDTH-1:0] a_in,
  input  logic [ALU_WIDTH-1:0] b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_WIDTH-1:0] quotient,
  output logic [ALU_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  div_state_t           state_r, state_nxt_s;
  logic [ALU_WIDTH-1:0] rem_r, rem_nxt_s;
  logic [ALU_WIDTH-1:0] div_r, div_nxt_s;
  logic [ALU_WIDTH-1:0] quot_r, quot_nxt_s;
  logic                 dbz_r, dbz_nxt_s;
  logic [ALU_WIDTH-1:0] diff_s;
  logic                 fits_s;

  alu_div_sequencer_sub u_sub (
    .minuend    (rem_r),
    .subtrahend (div_r),
    .difference (diff_s)
  );

  // A subtraction is only taken when it cannot wrap.
  assign fits_s = (rem_r >= div_r);

  // Next-state and next-datapath values for the divide sequence.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    div_nxt_s   = div_r;
    quot_nxt_s  = quot_r;
    dbz_nxt_s   = dbz_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          rem_nxt_s = a_in;
          div_nxt_s = b_in;
          if (b_in == 6'd0) begin
            state_nxt_s = DONE;
            quot_nxt_s  = DIV_ZERO_QUOT;
            dbz_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = RUN;
            quot_nxt_s  = 6'd0;
            dbz_nxt_s   = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (fits_s) begin
          rem_nxt_s  = diff_s;
          quot_nxt_s = quot_r + 6'd1;
        end else begin
          state_nxt_s = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rem_r   <= 6'd0;
      div_r   <= 6'd0;
      quot_r  <= 6'd0;
      dbz_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      div_r   <= div_nxt_s;
      quot_r  <= quot_nxt_s;
      dbz_r   <= dbz_nxt_s;
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == DONE);
  assign quotient    = quot_r;
  assign remainder   = rem_r;
  assign div_by_zero = dbz_r;

endmodule
